alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU in the MIPS core.
- Adds XOR, NOR and unsigned compare to the logic/arithmetic operations.
- Adds an iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage; the pipeline controller stalls on Busy and consumes results on Done.

Parameters:
- WIDTH, 32: datapath width in bits, must be at least 4. HI, LO and AluOut are all WIDTH bits.
- CW, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Start  in  1  operation request, sampled only in IDLE
- AluCtrl  in  4  operation select, sampled with Start
- A  in  WIDTH  operand A (rs)
- B  in  WIDTH  operand B (rt)
- AluOut  out  WIDTH  registered result
- Zero  out  1  registered, equals (AluOut == 0)
- Overflow  out  1  registered signed overflow flag for ADD/SUB
- Busy  out  1  multi-cycle operation in progress
- Done  out  1  one-cycle pulse: AluOut, Zero and Overflow are valid
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; AluOut=0, Zero=1, Overflow=0, Busy=0, Done=0, Hi=0, Lo=0; counter=0.
- Reset asserted mid-operation aborts it. HI/LO return to 0 and no Done is issued.
- AluCtrl encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 NOR
  - 0101 SLTU (unsigned)
  - 0110 SUB
  - 0111 SLT (signed, two's complement)
  - 1000 MULT
  - 1001 MULTU
  - 1010 DIV
  - 1011 DIVU
  - 1100 MFHI
  - 1101 MFLO
  - 1110 and 1111: AluOut=0, single-cycle
- SLT/SLTU result is {0...0,1} or 0.
- ADD/SUB: wrap modulo 2^WIDTH. Overflow=1 when the signed result is out of range; Overflow=0 for all other ops.
- Single-cycle ops (0000-0111, 1100-1110, 1111):
  - Start=1 in IDLE at edge k → AluOut/Zero/Overflow registered at edge k.
  - Done=1 for exactly the cycle after edge k. Busy stays 0.
- Multi-cycle ops (1000-1011), FSM IDLE → RUN → FIX → IDLE:
  - Edge k (IDLE, Start): latch |A|, |B| (raw for unsigned ops) and result signs. Clear accumulator, counter=0, Busy=1, state RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After WIDTH steps (edge k+WIDTH) go to FIX.
  - FIX (edge k+WIDTH+1): apply sign correction and write HI/LO. AluOut=LO, Zero from AluOut, Overflow=0, Busy=0, Done=1 for one cycle, state IDLE.
  - Total: Done visible WIDTH+1 cycles after the Start edge. Busy high for WIDTH+1 cycles.
- Multiply result: HI = upper WIDTH bits of the 2*WIDTH-bit product, LO = lower WIDTH bits.
- Divide result: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Divide by zero: LO = all-ones, HI = A. Same latency.
- Signed MIN / -1: LO = MIN, HI = 0.
- HI/LO change only in FIX or on reset. Single-cycle ops never modify them.
- Start while Busy=1 is ignored. AluCtrl/A/B may change freely during RUN.
- Start may be asserted in the cycle Done is high (state IDLE); it is accepted.
- Done never asserts without a preceding accepted Start.

Test Plan:
- Reset then idle: check AluOut=0, Zero=1, Busy=0, Done=0, Hi=Lo=0. Start ADD A=0x7FFFFFFF B=1 → next cycle AluOut=0x80000000, Overflow=1, Zero=0, Done=1 for one cycle.
- SUB A=5 B=5 → AluOut=0, Zero=1. SLT A=0xFFFFFFFF B=1 → 1. SLTU with the same operands → 0. NOR A=0 B=0 → 0xFFFFFFFF.
- MULT A=0xFFFFFFFD (-3) B=7 → Done exactly 33 cycles after Start, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, AluOut=Lo, Busy high for 33 cycles. Follow with MFHI → 0xFFFFFFFF.
- DIV A=-7 B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7 B=0 → Lo=0xFFFFFFFF, Hi=7. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Start pulsed at cycles 3 and 10 of a MULTU 0xFFFFFFFF×0xFFFFFFFF → both ignored, single Done, Hi=0xFFFFFFFE, Lo=1. Back-to-back Start during the Done cycle → accepted.
- Assert reset asynchronously mid-DIV (cycle 15) → Busy=0, Hi=Lo=0 immediately, no Done. Run WIDTH=8 parameter sweep: MULT 8-bit, Done at 9 cycles.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: registered EX-stage ALU plus an iterative multiply/divide unit.
// Single-cycle ops register their result on the Start edge. MULT/DIV run
// one shift-add / restoring shift-subtract step per clock on operand
// magnitudes, then a final FIX cycle applies the signs and writes HI/LO.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] AluOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // partial product high half / remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] mb_q, mb_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, out_q, out_d;
  logic             is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d, zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH-1:0]   sum, dif, alu_res, abs_a, abs_b, q_fix, r_fix;
  logic               alu_ovf, sgn_op, sa, sb;
  logic [WIDTH:0]     madd, rsh, rsub;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign sum = A + B;
  assign dif = A - B;

  // Single-cycle result and signed-overflow flag
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (AluCtrl)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0011: alu_res = A ^ B;
      4'b0100: alu_res = ~(A | B);
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0110: begin
        alu_res = dif;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1100: alu_res = hi_q;
      4'b1101: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Operand magnitudes: even codes (MULT, DIV) are signed
  assign sgn_op = ~AluCtrl[0];
  assign sa     = sgn_op & A[WIDTH-1];
  assign sb     = sgn_op & B[WIDTH-1];
  assign abs_a  = sa ? -A : A;
  assign abs_b  = sb ? -B : B;

  // Iteration datapath. rsub[WIDTH] is the borrow: the remainder is always
  // below the divisor, so the trial difference fits in WIDTH+1 signed bits.
  // For a zero divisor both branches leave acc = shifted dividend, so HI
  // ends up as A with no special case.
  assign madd     = {1'b0, acc_q} + (quo_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
  assign rsh      = {acc_q, quo_q[WIDTH-1]};
  assign rsub     = rsh - {1'b0, mb_q};
  assign prod     = {acc_q, quo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -quo_q : quo_q;
  assign r_fix    = neg_rem_q ? -acc_q : acc_q;

  // FSM next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    mb_d      = mb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    out_d     = out_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        if (AluCtrl[3:2] == 2'b10) begin
          is_div_d  = AluCtrl[1];
          mb_d      = AluCtrl[1] ? abs_b : abs_a;
          quo_d     = AluCtrl[1] ? abs_a : abs_b;
          acc_d     = '0;
          cnt_d     = '0;
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          div0_d    = (B == '0);
          state_d   = RUN;
        end else begin
          out_d  = alu_res;
          zero_d = (alu_res == '0);
          ovf_d  = alu_ovf;
          done_d = 1'b1;
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = rsub[WIDTH] ? rsh[WIDTH-1:0] : rsub[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~rsub[WIDTH]};
        end else begin
          acc_d = madd[WIDTH:1];
          quo_d = {madd[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = r_fix;
          lo_d = div0_q ? '1 : q_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        out_d   = lo_d;
        zero_d  = (lo_d == '0);
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      mb_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      out_q     <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      mb_q      <= mb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign AluOut   = out_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed vector table, back-to-back and busy-Start
// sequences, random ops against an arithmetic reference model, a WIDTH=8
// instance, and an asynchronous reset in the middle of a divide.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s32 = 1'b0, s8 = 1'b0;
  logic [3:0]  c32 = '0, c8 = '0;
  logic [31:0] a32 = '0, b32 = '0, o32, hi32, lo32;
  logic [7:0]  a8 = '0, b8 = '0, o8, hi8, lo8;
  logic        z32, ov32, bz32, d32, z8, ov8, bz8, d8;

  int          nchk = 0;
  int          nfail = 0;
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b;
    bit          pulse;
    logic [31:0] out;
    bit          z, ov;
    logic [31:0] hi, lo;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .Start(s32), .AluCtrl(c32), .A(a32), .B(b32),
    .AluOut(o32), .Zero(z32), .Overflow(ov32), .Busy(bz32), .Done(d32),
    .Hi(hi32), .Lo(lo32));

  alu_mdu #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .Start(s8), .AluCtrl(c8), .A(a8), .B(b8),
    .AluOut(o8), .Zero(z8), .Overflow(ov8), .Busy(bz8), .Done(d8),
    .Hi(hi8), .Lo(lo8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin s32 = st; c32 = c; a32 = a; b32 = b; end
    else begin s8 = st; c8 = c; a8 = a[7:0]; b8 = b[7:0]; end
  endtask

  task automatic sample(input int sel, output logic [31:0] o, output logic z, ov, bz, d,
                        output logic [31:0] h, l);
    if (sel == 0) begin o = o32; z = z32; ov = ov32; bz = bz32; d = d32; h = hi32; l = lo32; end
    else begin
      o = {24'd0, o8}; z = z8; ov = ov8; bz = bz8; d = d8; h = {24'd0, hi8}; l = {24'd0, lo8};
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int w);
    longint x;
    x = longint'(v);
    if (v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Reference model: plain integer arithmetic on sign-extended values.
  function automatic void model(input int w, input logic [3:0] c, input logic [31:0] a, b,
                                inout logic [31:0] hi, lo, output logic [31:0] out, output bit ov);
    logic [63:0] m, au, bu, pu;
    longint      as_, bs_, r, lim;
    m   = (64'd1 << w) - 64'd1;
    au  = {32'd0, a} & m;
    bu  = {32'd0, b} & m;
    as_ = sx(au, w);
    bs_ = sx(bu, w);
    lim = (longint'(1) << (w-1)) - 1;
    ov  = 1'b0;
    out = '0;
    case (c)
      4'h0: out = 32'(au & bu);
      4'h1: out = 32'(au | bu);
      4'h2: begin r = as_ + bs_; ov = (r > lim) || (r < -lim - 1); pu = r; out = 32'(pu & m); end
      4'h3: out = 32'(au ^ bu);
      4'h4: out = 32'(~(au | bu) & m);
      4'h5: out = {31'd0, au < bu};
      4'h6: begin r = as_ - bs_; ov = (r > lim) || (r < -lim - 1); pu = r; out = 32'(pu & m); end
      4'h7: out = {31'd0, as_ < bs_};
      4'h8, 4'h9: begin
        if (c == 4'h8) begin r = as_ * bs_; pu = r; end
        else pu = au * bu;
        hi = 32'((pu >> w) & m); lo = 32'(pu & m); out = lo;
      end
      4'hA, 4'hB: begin
        if (bu == 64'd0) begin lo = 32'(m); hi = 32'(au); end
        else if (c == 4'hA) begin
          r = as_ / bs_; pu = r; lo = 32'(pu & m);
          r = as_ % bs_; pu = r; hi = 32'(pu & m);
        end else begin
          lo = 32'((au / bu) & m); hi = 32'((au % bu) & m);
        end
        out = lo;
      end
      4'hC: out = hi;
      4'hD: out = lo;
      default: out = '0;
    endcase
  endfunction

  // Issue one op, follow it to Done and check latency, Busy span and results.
  task automatic run_op(input int sel, input string tag, input logic [3:0] c,
                        input logic [31:0] a, b, input bit pulse, input bit b2b,
                        input logic [31:0] eo, input bit ez, eov, input logic [31:0] ehi, elo);
    int          n, bc, lat;
    logic [31:0] o, h, l;
    logic        z, ov, bz, d;
    lat = (c[3:2] == 2'b10) ? ((sel == 0) ? 33 : 9) : 0;
    drive(sel, 1'b1, c, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 4'($urandom), $urandom, $urandom);
    n = 0; bc = 0;
    sample(sel, o, z, ov, bz, d, h, l);
    while (!d && n < lat + 20) begin
      if (bz) bc++;
      drive(sel, pulse && (n == 3 || n == 10), 4'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      n++;
      sample(sel, o, z, ov, bz, d, h, l);
    end
    drive(sel, 1'b0, 4'($urandom), $urandom, $urandom);
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy cycles"}, bc, lat);
    chk1({tag, " busy at done"}, bz, 1'b0);
    chk({tag, " AluOut"}, o, eo);
    chk1({tag, " Zero"}, z, ez);
    chk1({tag, " Overflow"}, ov, eov);
    chk({tag, " Hi"}, h, ehi);
    chk({tag, " Lo"}, l, elo);
    mhi[sel] = ehi;
    mlo[sel] = elo;
    if (!b2b) begin
      @(posedge clk); #1;
      sample(sel, o, z, ov, bz, d, h, l);
      chk1({tag, " done one cycle"}, d, 1'b0);
    end
  endtask

  task automatic mrun(input int sel, input string tag, input logic [3:0] c,
                      input logic [31:0] a, b, input bit pulse, input bit b2b);
    logic [31:0] h, l, o;
    bit          ov;
    h = mhi[sel]; l = mlo[sel];
    model((sel == 0) ? 32 : 8, c, a, b, h, l, o, ov);
    run_op(sel, tag, c, a, b, pulse, b2b, o, (o == '0), ov, h, l);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return 32'd1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o, h, l;
    logic        z, ov, bz, d;
    bit          multi, seen;
    logic [3:0]  c;

    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;

    tbl.push_back('{4'h2, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 0, 1, 0, 0});
    tbl.push_back('{4'h6, 32'h5, 32'h5, 0, 32'h0, 1, 0, 0, 0});
    tbl.push_back('{4'h7, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 0, 0, 0, 0});
    tbl.push_back('{4'h5, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0, 0, 0});
    tbl.push_back('{4'h4, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0});
    tbl.push_back('{4'h0, 32'hF0F0_1234, 32'hFF00_FF00, 0, 32'hF000_1200, 0, 0, 0, 0});
    tbl.push_back('{4'h1, 32'h0000_00F0, 32'h0000_0F00, 0, 32'h0000_0FF0, 0, 0, 0, 0});
    tbl.push_back('{4'h3, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 32'hF0F0_0F0F, 0, 0, 0, 0});
    tbl.push_back('{4'h6, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 0, 1, 0, 0});
    tbl.push_back('{4'h2, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 1, 0, 0, 0});
    tbl.push_back('{4'hE, 32'h1234_5678, 32'h9, 0, 32'h0, 1, 0, 0, 0});
    tbl.push_back('{4'hF, 32'h1234_5678, 32'h9, 0, 32'h0, 1, 0, 0, 0});
    tbl.push_back('{4'h8, 32'hFFFF_FFFD, 32'h7, 0, 32'hFFFF_FFEB, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    tbl.push_back('{4'hC, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0});
    tbl.push_back('{4'hD, 32'h0, 32'h0, 0, 32'hFFFF_FFEB, 0, 0, 0, 0});
    tbl.push_back('{4'hA, 32'hFFFF_FFF9, 32'h2, 0, 32'hFFFF_FFFD, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tbl.push_back('{4'hB, 32'h7, 32'h0, 0, 32'hFFFF_FFFF, 0, 0, 32'h7, 32'hFFFF_FFFF});
    tbl.push_back('{4'hC, 32'h0, 32'h0, 0, 32'h7, 0, 0, 0, 0});
    tbl.push_back('{4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 0, 32'h0, 32'h8000_0000});
    tbl.push_back('{4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h1, 0, 0, 32'hFFFF_FFFE, 32'h1});
    tbl.push_back('{4'hD, 32'h0, 32'h0, 0, 32'h1, 0, 0, 0, 0});
    tbl.push_back('{4'hC, 32'h0, 32'h0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0});

    // Reset state, during and just after reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst AluOut", o32, 32'h0);
    chk1("rst Zero", z32, 1'b1);
    chk1("rst Overflow", ov32, 1'b0);
    chk1("rst Busy", bz32, 1'b0);
    chk1("rst Done", d32, 1'b0);
    chk("rst Hi", hi32, 32'h0);
    chk("rst Lo", lo32, 32'h0);
    chk1("rst8 Zero", z8, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk1("idle Done", d32, 1'b0);
    chk1("idle Busy", bz32, 1'b0);

    // Directed vector table
    foreach (tbl[i]) begin
      multi = (tbl[i].c[3:2] == 2'b10);
      run_op(0, $sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].pulse, 1'b0,
             tbl[i].out, tbl[i].z, tbl[i].ov,
             multi ? tbl[i].hi : mhi[0], multi ? tbl[i].lo : mlo[0]);
    end

    // Start accepted in the Done cycle, after multi- and single-cycle ops
    mrun(0, "b2b mult", 4'h8, 32'd1234, 32'hFFFF_FFFB, 1'b0, 1'b1);
    mrun(0, "b2b add", 4'h2, 32'd100, 32'd23, 1'b0, 1'b1);
    mrun(0, "b2b divu", 4'hB, 32'd100, 32'd7, 1'b0, 1'b0);

    // Random ops, 32-bit
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      mrun(0, $sformatf("rnd32_%0d op%h", i, c), c, pick(32), pick(32),
           (c[3:2] == 2'b10) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0);
    end

    // WIDTH=8 instance
    run_op(1, "mult8", 4'h8, 32'hFD, 32'h7, 1'b0, 1'b0, 32'hEB, 0, 0, 32'hFF, 32'hEB);
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      mrun(1, $sformatf("rnd8_%0d op%h", i, c), c, pick(8), pick(8),
           (c[3:2] == 2'b10) && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0);
    end

    // Make HI/LO non-zero, then reset asynchronously in the middle of a DIV
    mrun(0, "pre-rst mult", 4'h9, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    drive(0, 1'b1, 4'hA, 32'h8765_4321, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (14) @(posedge clk);
    #1;
    chk1("mid-div Busy", bz32, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk1("async rst Busy", bz32, 1'b0);
    chk("async rst Hi", hi32, 32'h0);
    chk("async rst Lo", lo32, 32'h0);
    chk("async rst AluOut", o32, 32'h0);
    chk1("async rst Done", d32, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (d32 || d8) seen = 1'b1;
    end
    chk1("no Done after reset", seen, 1'b0);
    mrun(0, "post-rst mfhi", 4'hC, 32'h0, 32'h0, 1'b0, 1'b0);
    sample(0, o, z, ov, bz, d, h, l);
    chk("post-rst Lo", l, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
